// File: rtl/general_register_ext.sv
// General register for the CAN controller: error status, sticky send/receive
// flags, reset/init bit and bit-timing fields packed into one word. Sits between
// the CPU interface and the protocol core and merges both writers in one edge.
module general_register_ext #(
   parameter int SJW_W     = 3,
   parameter int TSEG1_W   = 3,
   parameter int TSEG2_W   = 3,
   parameter int RST_SJW   = 2,
   parameter int RST_TSEG1 = 5,
   parameter int RST_TSEG2 = 4,
   parameter int STICKY    = 1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  cpu,
   input  logic                                  can,
   input  logic                                  bof,
   input  logic                                  era,
   input  logic                                  erp,
   input  logic                                  war,
   input  logic [SJW_W-1:0]                      sjw,
   input  logic [TSEG1_W-1:0]                    tseg1,
   input  logic [TSEG2_W-1:0]                    tseg2,
   input  logic                                  ssp,
   input  logic                                  srp,
   input  logic                                  rsp,
   input  logic                                  ssc,
   input  logic                                  src,
   output logic [7+SJW_W+TSEG1_W+TSEG2_W-1:0]    register,
   output logic                                  irq,
   output logic                                  err_chg,
   output logic                                  cpu_ack,
   output logic                                  cpu_nak
);

   localparam int TIM_W = SJW_W + TSEG1_W + TSEG2_W;

   logic [3:0]         r_status;
   logic               r_ss;
   logic               r_sr;
   logic               r_rsp;
   logic [SJW_W-1:0]   r_sjw;
   logic [TSEG1_W-1:0] r_tseg1;
   logic [TSEG2_W-1:0] r_tseg2;
   logic               r_errChg;
   logic               r_ack;
   logic               r_nak;

   logic [3:0]         w_statusIn;
   logic [TIM_W-1:0]   w_timingIn;
   logic [TIM_W-1:0]   w_timingCur;
   logic               w_nak;
   logic               w_ssNext;
   logic               w_srNext;

   assign w_statusIn  = {bof, era, erp, war};
   assign w_timingIn  = {sjw, tseg1, tseg2};
   assign w_timingCur = {r_sjw, r_tseg1, r_tseg2};

   // A timing write is refused only while out of init mode and it would actually change the fields
   assign w_nak = cpu && !r_rsp && (w_timingIn != w_timingCur);

   // Next value of the event flags: sticky mode lets a controller set beat a CPU clear,
   // legacy mode is a plain load where the controller wins over the CPU
   always_comb begin
      w_ssNext = r_ss;
      w_srNext = r_sr;
      if (STICKY != 0) begin
         if (can && ssc) begin
            w_ssNext = 1'b1;
         end else if (cpu && ssp) begin
            w_ssNext = 1'b0;
         end
         if (can && src) begin
            w_srNext = 1'b1;
         end else if (cpu && srp) begin
            w_srNext = 1'b0;
         end
      end else begin
         if (can) begin
            w_ssNext = ssc;
            w_srNext = src;
         end else if (cpu) begin
            w_ssNext = ssp;
            w_srNext = srp;
         end
      end
   end

   // Register file update: status tracks the pins, timing only changes in init mode,
   // and the CPU handshake strobes are registered so they land one cycle after the write
   always_ff @(posedge clk) begin
      if (rst) begin
         r_status <= '0;
         r_ss     <= 1'b0;
         r_sr     <= 1'b0;
         r_rsp    <= 1'b0;
         r_sjw    <= SJW_W'(RST_SJW);
         r_tseg1  <= TSEG1_W'(RST_TSEG1);
         r_tseg2  <= TSEG2_W'(RST_TSEG2);
         r_errChg <= 1'b0;
         r_ack    <= 1'b0;
         r_nak    <= 1'b0;
      end else begin
         r_status <= w_statusIn;
         r_errChg <= (w_statusIn != r_status);
         r_ss     <= w_ssNext;
         r_sr     <= w_srNext;
         if (cpu) begin
            r_rsp <= rsp;
         end
         if (cpu && r_rsp) begin
            r_sjw   <= sjw;
            r_tseg1 <= tseg1;
            r_tseg2 <= tseg2;
         end
         r_nak <= w_nak;
         r_ack <= cpu && !w_nak;
      end
   end

   assign register = {r_status, r_ss, r_sr, r_rsp, r_sjw, r_tseg1, r_tseg2};
   assign irq      = r_ss | r_sr;
   assign err_chg  = r_errChg;
   assign cpu_ack  = r_ack;
   assign cpu_nak  = r_nak;

endmodule
